// File: rtl/instr_prefetch_buffer_if.sv
// Bundle of the fetch-side memory bus, the core-side instruction handshake and
// the redirect request. Modport master is the prefetch buffer, slave is its environment.
interface instr_prefetch_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;

  modport master (
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with a DEPTH-entry in-order FIFO and redirect flush.
// Optional macro PREFETCH_STALL_CNT_EN adds stall_cnt_o (cycles the core waited on an empty buffer).
module instr_prefetch_buffer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
`ifdef PREFETCH_STALL_CNT_EN
  output logic [31:0]              stall_cnt_o,
`endif
  instr_prefetch_buffer_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic                  w_drop;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count, r_outst, r_discard;

  logic                  w_grant, w_push, w_pop, w_valid, w_req_nxt;
  logic [ADDR_WIDTH-1:0] w_tgt, w_fetch_nxt;
  logic [CW-1:0]         w_count_nxt, w_outst_nxt, w_discard_nxt;

  assign w_valid = (r_count != '0);
  assign w_grant = r_req & bus.mem_gnt_i;
  assign w_tgt   = bus.redirect_pc_i & ~ADDR_WIDTH'(3);
  assign w_push  = bus.mem_rvalid_i & ~bus.redirect_i & ~w_drop;
  // A pop in the redirect cycle is swallowed by the flush.
  assign w_pop   = w_valid & bus.instr_ready_i & ~bus.redirect_i;

  assign w_outst_nxt = r_outst + CW'(w_grant) - CW'(bus.mem_rvalid_i);
  assign w_count_nxt = bus.redirect_i ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  assign w_fetch_nxt = bus.redirect_i ? w_tgt
                     : (w_grant ? r_fetch_pc + ADDR_WIDTH'(4) : r_fetch_pc);
  // Registered request reflects next cycle's occupancy so the cap is never exceeded.
  assign w_req_nxt   = ({1'b0, w_count_nxt} + {1'b0, w_outst_nxt}) < (CW+1)'(DEPTH);

  // Everything still in flight after a redirect is stale, including a same-cycle grant.
  always_comb begin
    w_discard_nxt = r_discard;
    if (bus.redirect_i)
      w_discard_nxt = w_outst_nxt;
    else if (bus.mem_rvalid_i && w_drop)
      w_discard_nxt = r_discard - CW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= RUN;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_discard_nxt != '0) w_state_nxt = DRAIN;
      DRAIN:   if (w_discard_nxt == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_drop = (r_state == DRAIN);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      r_req      <= w_req_nxt;
      r_addr     <= w_fetch_nxt;
      r_fetch_pc <= w_fetch_nxt;
      r_count    <= w_count_nxt;
      r_outst    <= w_outst_nxt;
      r_discard  <= w_discard_nxt;
      if (bus.redirect_i) begin
        r_resp_pc <= w_tgt;
        r_wptr    <= '0;
        r_rptr    <= '0;
      end else begin
        if (w_push) begin
          r_resp_pc <= r_resp_pc + ADDR_WIDTH'(4);
          r_wptr    <= r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_data[r_wptr] <= bus.mem_rdata_i;
      r_pc[r_wptr]   <= r_resp_pc;
    end
  end

  assign bus.mem_req_o     = r_req;
  assign bus.mem_addr_o    = r_addr;
  assign bus.instr_valid_o = w_valid;
  assign bus.instr_o       = r_data[r_rptr];
  assign bus.instr_pc_o    = r_pc[r_rptr];

`ifdef PREFETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      r_stall_cnt <= '0;
    else if (bus.instr_ready_i && !w_valid && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt_o = r_stall_cnt;
`endif

  a_occupancy_cap: assert property (@(posedge clk_i) disable iff (!reset_ni)
    ({1'b0, r_count} + {1'b0, r_outst}) <= (CW+1)'(DEPTH));
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!reset_ni)
    bus.mem_rvalid_i |-> (r_outst != '0));
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized scoreboard bench for instr_prefetch_buffer: a memory model tags each grant with a
// redirect epoch, and the core-side monitor checks the delivered {instr, pc} stream in order.
module tb_instr_prefetch_buffer;
  localparam int DEPTH = 4;

  typedef struct { logic [31:0] a; int ep; } req_t;
  typedef struct { logic [31:0] d; logic [31:0] pc; } exp_t;

  logic clk_i, reset_ni, armed;
`ifdef PREFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
  int unsigned model_stall;
`endif

  instr_prefetch_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_prefetch_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
`ifdef PREFETCH_STALL_CNT_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .bus         (bus)
  );

  int n_cmp = 0, n_fail = 0;
  req_t pend[$];
  exp_t exp_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] fetch_pc = 32'h0;
  int cur_ep = 0, gnt_cnt = 0;
  int p_gnt = 100, p_rv = 100, p_rdy = 100, p_redir = 0, gnt_limit = DEPTH;
  bit hold_rv = 0, force_redir = 0;
  logic [31:0] force_tgt = 32'h0;
  bit ev_ok = 0, ev_gnt, ev_rv, ev_redir;
  logic [31:0] ev_tgt;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) armed <= 1'b0;
    else           armed <= 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   64'(bus.mem_req_o),     64'd0);
    chk({tag, "_addr"},  64'(bus.mem_addr_o),    64'd0);
    chk({tag, "_valid"}, 64'(bus.instr_valid_o), 64'd0);
    chk({tag, "_instr"}, 64'(bus.instr_o),       64'd0);
    chk({tag, "_pc"},    64'(bus.instr_pc_o),    64'd0);
  endtask

  task automatic zero_inputs();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    bus.instr_ready_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = '0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    force_tgt = tgt; force_redir = 1;
    for (int i = 0; i < 10 && force_redir; i++) @(negedge clk_i);
    chk("redirect_issued", 64'(force_redir), 64'd0);
    pop_log.delete();
  endtask

  task automatic wait_pops(input int k, input int budget);
    for (int i = 0; i < budget && pop_log.size() < k; i++) @(negedge clk_i);
    chk("pop_count_reached", 64'(pop_log.size() >= k), 64'd1);
  endtask

  // Memory and core-input driver; also maintains the reference model at each clock edge.
  initial begin : driver
    req_t it;
    forever begin
      @(posedge clk_i);
      if (reset_ni && ev_ok) begin
        if (ev_rv && pend.size() != 0) begin
          it = pend.pop_front();
          if (!ev_redir && it.ep == cur_ep) exp_q.push_back('{mem_word(it.a), it.a});
        end
        if (ev_gnt) begin
          pend.push_back('{fetch_pc, cur_ep});
          fetch_pc = fetch_pc + 32'd4;
          gnt_cnt++;
        end
        if (ev_redir) begin
          cur_ep++;
          fetch_pc = ev_tgt & ~32'd3;
          exp_q.delete();
        end
      end
      ev_ok = 0;
      #1;
      if (!reset_ni) zero_inputs();
      else begin
        bus.mem_gnt_i = ($urandom_range(99) < p_gnt) && (pend.size() < gnt_limit);
        if (pend.size() != 0 && !hold_rv && $urandom_range(99) < p_rv) begin
          bus.mem_rvalid_i = 1; bus.mem_rdata_i = mem_word(pend[0].a);
        end else begin
          bus.mem_rvalid_i = 0; bus.mem_rdata_i = $urandom;
        end
        bus.instr_ready_i = ($urandom_range(99) < p_rdy);
        if (force_redir) begin
          bus.redirect_i = 1; bus.redirect_pc_i = force_tgt; force_redir = 0;
        end else if ($urandom_range(99) < p_redir) begin
          bus.redirect_i = 1;
          bus.redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(7)))
                                                       : 32'($urandom);
        end else begin
          bus.redirect_i = 0; bus.redirect_pc_i = $urandom;
        end
      end
      @(negedge clk_i);
      if (reset_ni && armed) begin
        ev_gnt = bus.mem_req_o & bus.mem_gnt_i;
        ev_rv = bus.mem_rvalid_i;
        ev_redir = bus.redirect_i;
        ev_tgt = bus.redirect_pc_i;
        ev_ok = 1;
        if (ev_gnt) chk("fetch_addr", 64'(bus.mem_addr_o), 64'(fetch_pc));
      end
    end
  end

  // Core-side monitor: occupancy-driven request/valid checks and in-order delivery.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (reset_ni && armed) begin
        chk("mem_req", 64'(bus.mem_req_o), 64'((exp_q.size() + pend.size()) < DEPTH));
        chk("instr_valid", 64'(bus.instr_valid_o), 64'(exp_q.size() != 0));
`ifdef PREFETCH_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt_o), 64'(model_stall));
        if (bus.instr_ready_i && !bus.instr_valid_o) model_stall++;
`endif
        if (bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("instr", 64'(bus.instr_o), 64'(e.d));
          chk("instr_pc", 64'(bus.instr_pc_o), 64'(e.pc));
          pop_log.push_back(bus.instr_pc_o);
        end
      end
    end
  end

  initial begin : main
    reset_ni = 0;
    zero_inputs();
`ifdef PREFETCH_STALL_CNT_EN
    model_stall = 0;
`endif
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk_i);
    reset_ni = 1;
    // Back-to-back streaming: valid from the third cycle after release, then every cycle.
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk_i);
      chk("startup_valid", 64'(bus.instr_valid_o), 64'(k >= 3));
    end

    // Asynchronous reset mid-burst, then fill with the core stalled.
    @(negedge clk_i); #2 reset_ni = 0;
    #1 check_reset_outputs("midburst");
    exp_q.delete(); pend.delete(); fetch_pc = 32'h0; cur_ep++; gnt_cnt = 0;
`ifdef PREFETCH_STALL_CNT_EN
    model_stall = 0;
`endif
    p_rdy = 0;
    @(negedge clk_i); reset_ni = 1;
    repeat (15) @(negedge clk_i);
    chk("fill_grants", 64'(gnt_cnt), 64'(DEPTH));
    chk("fill_req_low", 64'(bus.mem_req_o), 64'd0);
    chk("fill_valid", 64'(bus.instr_valid_o), 64'd1);

    // Three stale requests in flight, redirect to an unaligned target.
    p_rdy = 100; gnt_limit = 3; hold_rv = 1;
    for (int i = 0; i < 40 && !(pend.size() == 3 && exp_q.size() == 0); i++) @(negedge clk_i);
    chk("three_outstanding", 64'(pend.size()), 64'd3);
    do_redirect(32'h0000_0103);
    hold_rv = 0; gnt_limit = DEPTH;
    wait_pops(1, 60);
    chk("redir_first_pc", 64'(pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF), 64'h100);

    // Redirect while grant and response coincide.
    repeat (8) @(negedge clk_i);
    do_redirect(32'h0000_0200);
    wait_pops(1, 60);
    chk("redir_gnt_rv_pc", 64'(pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF), 64'h200);

    // Address wrap at the top of the space.
    repeat (5) @(negedge clk_i);
    do_redirect(32'hFFFF_FFFC);
    wait_pops(2, 60);
    chk("wrap_pc0", 64'(pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF), 64'hFFFF_FFFC);
    chk("wrap_pc1", 64'(pop_log.size() > 1 ? pop_log[1] : 32'hDEAD_BEEF), 64'h0);

    // Randomized traffic with occasional redirects.
    for (int b = 0; b < 15; b++) begin
      p_gnt = 30 + int'($urandom_range(70));
      p_rv = 30 + int'($urandom_range(70));
      p_rdy = 20 + int'($urandom_range(80));
      p_redir = int'($urandom_range(8));
      repeat (200) @(negedge clk_i);
    end

    // Drain: no new grants, everything in flight must be returned and consumed.
    p_redir = 0; p_gnt = 0; p_rv = 100; p_rdy = 100;
    repeat (30) @(negedge clk_i);
    chk("drain_expected_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_pending_empty", 64'(pend.size()), 64'd0);
    chk("drain_valid_low", 64'(bus.instr_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end
endmodule
